// File: rtl/snes_pad_pkg.sv
// ============================================================================
//  Module   : snes_pad_pkg
//  Brief    : Shared constants and types for the SNES pad port responder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package snes_pad_pkg;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    localparam int          NUM_BTNS  = 12;
    localparam int          NUM_PADS  = 4;
    localparam int          WORD_BITS = 16;
    localparam int          CNT_W     = 5;
    localparam logic [3:0]  PAD_ID    = 4'b0000;
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(WORD_BITS);

    typedef enum logic {
        PAD_STD  = 1'b0,
        PAD_MTAP = 1'b1
    } pad_mode_e;

endpackage

`default_nettype wire

// File: rtl/snes_pad_shifter.sv
// ============================================================================
//  Module   : snes_pad_shifter
//  Brief    : One pad channel: latched 16-bit word plus saturating bit counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module snes_pad_shifter
    import snes_pad_pkg::*;
(
    input  logic                mclk,
    input  logic                rst,
    input  logic                load,
    input  logic                adv,
    input  logic [NUM_BTNS-1:0] buttons,
    output logic                bit_out
);

    logic [WORD_BITS-1:0] word_q, word_d;
    logic [CNT_W-1:0]     cnt_q,  cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (load) begin
            word_d = {PAD_ID, buttons};
            cnt_d  = '0;
        end else if (adv && (cnt_q < CNT_SAT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Looks at the post-update position so the registered pin in the parent
    // shows the new bit exactly one mclk after the causing cycle.
    always_comb begin
        bit_out = (cnt_d >= CNT_SAT) ? 1'b1 : word_d[cnt_d[3:0]];
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/snes_pad_port.sv
// ============================================================================
//  Module   : snes_pad_port
//  Brief    : SNES controller-port responder (standard pad or 4-pad multitap).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module snes_pad_port
    import snes_pad_pkg::*;
(
    input  logic                         mclk,
    input  logic                         rst,
    input  logic                         mode,
    input  logic [NUM_PADS*NUM_BTNS-1:0] pads,
    input  logic                         joy_strb,
    input  logic                         joy_clk,
    input  logic                         joy_p6,
    output logic [1:0]                   joy_di
);

    pad_mode_e           mode_q, mode_d;
    logic                clk_prev_q;
    logic [1:0]          joy_di_q, joy_di_d;
    logic                clk_rise;
    logic                adv_a, adv_b;
    logic [NUM_PADS-1:0] pad_bit;
    logic [1:0]          logical;

    assign clk_rise = joy_clk & ~clk_prev_q;
    assign mode_d   = joy_strb ? pad_mode_e'(mode) : mode_q;
    assign adv_a    = clk_rise & ~joy_strb & ((mode_q == PAD_STD) | joy_p6);
    assign adv_b    = clk_rise & ~joy_strb & (mode_q == PAD_MTAP) & ~joy_p6;

    generate
        for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
            snes_pad_shifter u_shifter (
                .mclk    (mclk),
                .rst     (rst),
                .load    (joy_strb),
                .adv     ((i < 2) ? adv_a : adv_b),
                .buttons (pads[i*NUM_BTNS +: NUM_BTNS]),
                .bit_out (pad_bit[i])
            );
        end
    endgenerate

    always_comb begin
        logical = {1'b0, pad_bit[0]};
        if (mode_d == PAD_MTAP) begin
            if (joy_strb) begin
                logical = {1'b1, pad_bit[0]};
            end else if (joy_p6) begin
                logical = {pad_bit[1], pad_bit[0]};
            end else begin
                logical = {pad_bit[3], pad_bit[2]};
            end
        end
        joy_di_d = ~logical;
    end

    // clk_prev resets high so a joy_clk already high after reset is not an edge.
    always_ff @(posedge mclk) begin
        if (rst) begin
            mode_q     <= PAD_STD;
            clk_prev_q <= 1'b1;
            joy_di_q   <= 2'b11;
        end else begin
            mode_q     <= mode_d;
            clk_prev_q <= joy_clk;
            joy_di_q   <= joy_di_d;
        end
    end

    assign joy_di = joy_di_q;

endmodule

`default_nettype wire

// File: tb/tb_snes_pad_port.sv
// ============================================================================
//  Module   : tb_snes_pad_port
//  Brief    : Self-checking bench for snes_pad_port against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snes_pad_port;

    logic        mclk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0;
    logic [47:0] pads = '0;
    logic        joy_strb = 1'b0;
    logic        joy_clk = 1'b1;
    logic        joy_p6 = 1'b1;
    logic [1:0]  joy_di;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Behavioural model: latched words, read positions, latched mode.
    logic [15:0] m_word [4];
    int          m_pos  [4];
    logic        m_mode;
    logic        m_prev;
    logic [1:0]  m_exp;

    snes_pad_port dut (
        .mclk     (mclk),
        .rst      (rst),
        .mode     (mode),
        .pads     (pads),
        .joy_strb (joy_strb),
        .joy_clk  (joy_clk),
        .joy_p6   (joy_p6),
        .joy_di   (joy_di)
    );

    always #5 mclk = ~mclk;

    function automatic logic pad_bit(int p);
        if (m_pos[p] >= 16) return 1'b1;
        return m_word[p][m_pos[p]];
    endfunction

    task automatic model_update();
        logic [1:0] l;
        bit         sel;
        if (rst) begin
            for (int p = 0; p < 4; p++) begin
                m_word[p] = '0;
                m_pos[p]  = 0;
            end
            m_mode = 1'b0;
            m_prev = 1'b1;
            m_exp  = 2'b11;
        end else begin
            if (joy_strb) begin
                for (int p = 0; p < 4; p++) begin
                    m_word[p] = {4'b0000, pads[p*12 +: 12]};
                    m_pos[p]  = 0;
                end
                m_mode = mode;
            end else if (joy_clk && !m_prev) begin
                for (int p = 0; p < 4; p++) begin
                    if (!m_mode) sel = (p < 2);
                    else         sel = joy_p6 ? (p < 2) : (p >= 2);
                    if (sel && m_pos[p] < 16) m_pos[p] = m_pos[p] + 1;
                end
            end
            m_prev = joy_clk;
            if (!m_mode)        l = {1'b0, pad_bit(0)};
            else if (joy_strb)  l = {1'b1, pad_bit(0)};
            else if (joy_p6)    l = {pad_bit(1), pad_bit(0)};
            else                l = {pad_bit(3), pad_bit(2)};
            m_exp = ~l;
        end
    endtask

    task automatic chk(string tag, logic [1:0] got, logic [1:0] want);
        n_chk++;
        assert (got === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s joy_di=%b expected=%b", tag, got, want);
        end
    endtask

    task automatic step(string tag);
        @(posedge mclk);
        model_update();
        @(negedge mclk);
        chk(tag, joy_di, m_exp);
    endtask

    task automatic strobe(int n, string tag);
        joy_strb = 1'b1;
        joy_clk  = 1'b1;
        for (int i = 0; i < n; i++) step(tag);
        joy_strb = 1'b0;
    endtask

    task automatic pulse(string tag);
        joy_clk = 1'b0;
        step(tag);
        joy_clk = 1'b1;
        step(tag);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        step("reset");
        step("reset");
        chk("reset_lit", joy_di, 2'b11);
        rst = 1'b0;

        // Standard pad, B pressed
        mode = 1'b0;
        pads = 48'h000_000_000_001;
        strobe(4, "t1_strobe");
        chk("t1_pre_lit", joy_di, 2'b10);
        for (int i = 0; i < 20; i++) pulse("t1_read");
        chk("t1_sat_lit", joy_di, 2'b10);

        // Standard pad, R plus ID nibble and saturation
        pads = 48'h000_000_000_800;
        strobe(2, "t2_strobe");
        for (int i = 0; i < 21; i++) pulse("t2_read");

        // Multitap presence, pad1 A
        mode   = 1'b1;
        joy_p6 = 1'b1;
        pads   = 48'h000_000_100_000;
        joy_strb = 1'b1;
        step("t3_strobe");
        step("t3_strobe");
        chk("t3_present_lit", joy_di, 2'b01);
        joy_strb = 1'b0;
        for (int i = 0; i < 10; i++) pulse("t3_read");

        // Pair independence
        pads = 48'h000_002_000_008;
        strobe(2, "t4_strobe");
        for (int i = 0; i < 3; i++) pulse("t4_pairA");
        joy_p6 = 1'b0;
        step("t4_p6lo");
        pulse("t4_pairB");
        joy_p6 = 1'b1;
        step("t4_p6hi");

        // Latch isolation and restart
        mode = 1'b0;
        pads = 48'h0000_0000_0A5A;
        strobe(2, "t5_strobe");
        for (int i = 0; i < 4; i++) pulse("t5_read");
        pads = 48'hFFFF_FFFF_FFFF;
        for (int i = 0; i < 3; i++) pulse("t5_iso");
        strobe(1, "t5_restrobe");
        for (int i = 0; i < 3; i++) pulse("t5_restart");

        // Strobe fall coinciding with joy_clk rise
        joy_strb = 1'b1;
        joy_clk  = 1'b0;
        step("t7_strobe");
        joy_strb = 1'b0;
        joy_clk  = 1'b1;
        step("t7_fall_rise");
        step("t7_hold");

        // Reset mid-read
        pads = 48'h0000_0000_0FFF;
        strobe(2, "t6_strobe");
        for (int i = 0; i < 5; i++) pulse("t6_read");
        rst = 1'b1;
        step("t6_rst");
        chk("t6_rst_lit", joy_di, 2'b11);
        rst = 1'b0;
        for (int i = 0; i < 18; i++) pulse("t6_after");

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            joy_strb = ($urandom_range(0, 15) == 0);
            joy_clk  = 1'($urandom);
            if ($urandom_range(0, 7) == 0) joy_p6 = ~joy_p6;
            if ($urandom_range(0, 15) == 0) mode = 1'($urandom);
            if ($urandom_range(0, 7) == 0) pads = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
            rst = ($urandom_range(0, 199) == 0);
            step("random");
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
